// File: rtl/tnn_seq_threshold_neuron.sv
//------------------------------------------------------------------------------
// Module   : tnn_seq_threshold_neuron
// Purpose  : Streaming threshold neuron. The first N_POS operands of a frame
//            are added and the next N_NEG are subtracted. The sign of the
//            frame sum gives a one-bit decision, held in HOLD until consumed.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tnn_seq_threshold_neuron #(
  parameter int WIDTH   = 3,
  parameter int N_POS   = 2,
  parameter int N_NEG   = 3,
  parameter int GE_MODE = 0,
  parameter int ACC_W   = WIDTH + $clog2(N_POS + N_NEG) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [ACC_W-1:0] out_diff
);

  localparam int TOTAL = N_POS + N_NEG;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] NEG_BASE = IDX_W'(N_POS);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;

  logic             accept;
  logic             is_pos;
  logic             is_last;
  logic [ACC_W-1:0] operand_ext;
  logic [ACC_W-1:0] sum_next;
  logic             decision;

  assign in_ready    = (state == ST_ACCUM) & ~clear;
  assign accept      = in_valid & in_ready;
  assign is_pos      = (idx < NEG_BASE);
  assign is_last     = (idx == LAST_IDX);
  assign operand_ext = {{(ACC_W - WIDTH){1'b0}}, in_data};

  // ACC_W is sized so this never wraps for any operand values.
  always_comb begin
    sum_next = acc;
    if (is_pos) begin
      sum_next = acc + operand_ext;
    end else begin
      sum_next = acc - operand_ext;
    end
  end

  generate
    if (GE_MODE != 0) begin : g_ge
      assign decision = ~sum_next[ACC_W-1];
    end else begin : g_gt
      assign decision = ~sum_next[ACC_W-1] & (|sum_next);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_diff  <= '0;
    end else if (clear) begin
      // Abort wins over a simultaneous output handshake; out_bit/out_diff keep history.
      state     <= ST_ACCUM;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            if (is_last) begin
              out_diff  <= sum_next;
              out_bit   <= decision;
              out_valid <= 1'b1;
              acc       <= '0;
              idx       <= '0;
              state     <= ST_HOLD;
            end else begin
              acc <= sum_next;
              idx <= idx + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tnn_seq_threshold_neuron.sv
//------------------------------------------------------------------------------
// Module   : tb_tnn_seq_threshold_neuron
// Purpose  : Directed, table-driven bench for tnn_seq_threshold_neuron with a
//            GT-mode and a GE-mode instance fed from the same stimulus.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tnn_seq_threshold_neuron;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [2:0] in_data;
  logic       out_ready;

  logic       in_ready, out_valid, out_bit;
  logic [6:0] out_diff;
  logic       in_ready_ge, out_valid_ge, out_bit_ge;
  logic [6:0] out_diff_ge;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [14:0]       ops;      // op0 in [14:12] .. op4 in [2:0]
    logic              exp_bit;
    logic              exp_bit_ge;
    logic signed [6:0] exp_diff;
  } vec_t;

  vec_t vecs [8];

  tnn_seq_threshold_neuron dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_diff(out_diff)
  );

  tnn_seq_threshold_neuron #(.GE_MODE(1)) dut_ge (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_ge), .in_data(in_data),
    .out_valid(out_valid_ge), .out_ready(out_ready),
    .out_bit(out_bit_ge), .out_diff(out_diff_ge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_op(input logic [2:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("in_ready_timeout", int'(ok), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ops(input logic [14:0] ops);
    logic [14:0] o;
    o = ops;
    for (int k = 0; k < 5; k++) send_op(o[14-3*k -: 3]);
  endtask

  // Full frame with out_ready high: checks result and 1-cycle pulse.
  task automatic run_frame(input vec_t v, input string tag);
    send_ops(v.ops);
    @(negedge clk);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_bit"}, int'(out_bit), int'(v.exp_bit));
    check({tag, "_diff"}, int'($signed(out_diff)), int'(v.exp_diff));
    check({tag, "_bit_ge"}, int'(out_bit_ge), int'(v.exp_bit_ge));
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_pulse_end"}, int'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulse_cnt;
    int pulse_at [2];

    vecs[0] = '{ops: {3'd7, 3'd7, 3'd0, 3'd0, 3'd0}, exp_bit: 1'b1, exp_bit_ge: 1'b1, exp_diff: 7'sd14};
    vecs[1] = '{ops: {3'd3, 3'd2, 3'd1, 3'd2, 3'd2}, exp_bit: 1'b0, exp_bit_ge: 1'b1, exp_diff: 7'sd0};
    vecs[2] = '{ops: {3'd0, 3'd0, 3'd7, 3'd7, 3'd7}, exp_bit: 1'b0, exp_bit_ge: 1'b0, exp_diff: -7'sd21};
    vecs[3] = '{ops: {3'd1, 3'd1, 3'd0, 3'd0, 3'd0}, exp_bit: 1'b1, exp_bit_ge: 1'b1, exp_diff: 7'sd2};
    vecs[4] = '{ops: {3'd5, 3'd4, 3'd3, 3'd3, 3'd3}, exp_bit: 1'b0, exp_bit_ge: 1'b1, exp_diff: 7'sd0};
    vecs[5] = '{ops: {3'd6, 3'd0, 3'd2, 3'd2, 3'd1}, exp_bit: 1'b1, exp_bit_ge: 1'b1, exp_diff: 7'sd1};
    vecs[6] = '{ops: {3'd0, 3'd1, 3'd1, 3'd1, 3'd0}, exp_bit: 1'b0, exp_bit_ge: 1'b0, exp_diff: -7'sd1};
    vecs[7] = '{ops: {3'd7, 3'd7, 3'd7, 3'd7, 3'd0}, exp_bit: 1'b0, exp_bit_ge: 1'b1, exp_diff: 7'sd0};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bit", int'(out_bit), 0);
    check("rst_out_diff", int'(out_diff), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames, in_valid continuously high
    pulse_cnt = 0;
    in_valid  = 1'b1;
    in_data   = 3'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (pulse_cnt < 2) pulse_at[pulse_cnt] = i;
        pulse_cnt++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_pulse_count", pulse_cnt, 2);
    if (pulse_cnt >= 2) check("b2b_period", pulse_at[1] - pulse_at[0], 6);

    // Backpressure: decision held while out_ready low, in_valid ignored
    out_ready = 1'b0;
    send_ops(vecs[0].ops);
    in_valid = 1'b1;
    in_data  = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_bit", int'(out_bit), 1);
      check("bp_diff", int'($signed(out_diff)), 14);
      check("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("bp_release_valid", int'(out_valid), 1);
    check("bp_release_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_valid", int'(out_valid), 0);
    check("bp_after_in_ready", int'(in_ready), 1);
    check("bp_after_diff_kept", int'($signed(out_diff)), 14);
    @(posedge clk);
    #1;
    run_frame(vecs[6], "bp_next");

    // clear after 3 operands with in_valid held high
    send_op(3'd7); send_op(3'd7); send_op(3'd0);
    in_valid = 1'b1;
    in_data  = 3'd7;
    clear    = 1'b1;
    @(negedge clk);
    check("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    run_frame(vecs[3], "clr_next");

    // clear while holding a decision discards it
    out_ready = 1'b0;
    send_ops(vecs[0].ops);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("clr_hold_valid", int'(out_valid), 0);
    check("clr_hold_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    run_frame(vecs[5], "clr_hold_next");

    // Asynchronous reset mid-frame
    send_op(3'd7); send_op(3'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_valid", int'(out_valid), 0);
    check("arst_mid_bit", int'(out_bit), 0);
    check("arst_mid_diff", int'(out_diff), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(vecs[1], "arst_mid_next");

    // Asynchronous reset while holding a decision
    out_ready = 1'b0;
    send_ops(vecs[0].ops);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", int'(out_valid), 0);
    check("arst_hold_bit", int'(out_bit), 0);
    check("arst_hold_diff", int'(out_diff), 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_frame(vecs[2], "arst_hold_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/tnn_seq_threshold_neuron.md
# tnn_seq_threshold_neuron

Sequential, parametrised threshold neuron for the approximate TNN inference datapath. It streams one unsigned operand per handshake. The first N_POS operands of a frame are added to an accumulator and the next N_NEG are subtracted. At frame end it emits a one-bit decision: positive-group sum greater than (or, in GE mode, greater than or equal to) the negative-group sum. It generalises the fixed 5×3-bit combinational comparator neuron to arbitrary width, operand counts and tie mode, and adds flow control, backpressure and frame abort.

## Interface
- WIDTH, 3, operand bit width (≥1)
- N_POS, 2, positively weighted operands per frame (≥1)
- N_NEG, 3, negatively weighted operands per frame (≥1)
- GE_MODE, 0, 0: decision = pos > neg; 1: decision = pos ≥ neg
- ACC_W, WIDTH+$clog2(N_POS+N_NEG)+1, signed accumulator width (derived; do not override)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous frame abort, priority over all other inputs
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid & in_ready
- in_data  in  WIDTH  unsigned operand
- out_valid  out  1  decision valid
- out_ready  in  1  consumer accepts decision
- out_bit  out  1  neuron decision
- out_diff  out  ACC_W  signed pos_sum − neg_sum for the frame (debug/calibration)

Clock and reset are decided: one clock, clk; reset is asynchronous and active-low, rst_n.

## Operation
- FSM states: ACCUM and HOLD. Counter idx runs 0..N_POS+N_NEG−1 and marks the operand position in the frame.
- Reset values: state = ACCUM, idx = 0, acc = 0, out_valid = 0, out_bit = 0, out_diff = 0.
- in_ready = (state == ACCUM) & ~clear. This is combinational and does not depend on in_valid.
- Behaviour in ACCUM when an operand is accepted:
  - If idx < N_POS: acc ← acc + zero-extended in_data.
  - Otherwise: acc ← acc − zero-extended in_data.
  - If idx ≠ last: idx increments.
  - If idx == last: compute final = acc ± in_data, then:
    - out_diff ← final
    - out_bit ← (final > 0), or (final ≥ 0) when GE_MODE = 1
    - out_valid ← 1, acc ← 0, idx ← 0, state ← HOLD
- HOLD: out_valid, out_bit and out_diff stay stable until out_valid & out_ready. On that cycle: out_valid ← 0, state ← ACCUM. out_bit and out_diff keep their last values.
- clear = 1, in any state: acc ← 0, idx ← 0, out_valid ← 0, state ← ACCUM. Any operand presented in the same cycle is not accepted (in_ready is already 0). A pending decision is discarded.
- Arithmetic: all sums are two's complement in ACC_W bits. ACC_W guarantees no overflow for any operand values (default range −21..+14 fits in 7 bits).
- in_valid is ignored in HOLD. There is no operand skid buffer.

## Timing
- Operand throughput: 1 per cycle in ACCUM.
- Latency: last operand accepted at edge t → out_valid = 1 after edge t (visible in cycle t+1).
- Minimum frame period: N_POS+N_NEG+1 cycles, since the HOLD handshake costs at least 1 cycle. in_ready returns to 1 in the cycle after the output handshake; there is no same-cycle bypass.
- out_ready held high: out_valid is high for exactly 1 cycle per frame.
- rst_n asserted mid-frame or in HOLD: all state returns to reset values immediately (asynchronous). Deassertion is synchronised externally.
- clear and an output handshake in the same cycle: clear wins and the result counts as consumed.

## Test plan
- Default parameters, frame 7,7 | 0,0,0 with out_ready = 1:
  - out_valid pulses 1 cycle after the 5th acceptance.
  - out_bit = 1, out_diff = +14.
- Tie frame 3,2 | 1,2,2:
  - GE_MODE = 0: out_bit = 0, out_diff = 0.
  - Rebuild with GE_MODE = 1: out_bit = 1.
- Extreme negative frame 0,0 | 7,7,7: out_bit = 0, out_diff = −21 (7'b1101011). No wrap.
- Backpressure:
  - out_ready = 0 for 4 cycles after a frame: out_valid, out_bit and out_diff stay stable, and in_ready = 0 throughout.
  - Next frame is accepted starting the cycle after out_ready rises.
  - Back-to-back frames with continuous in_valid give a period of 6 cycles.
- clear after 3 operands, with in_valid held high:
  - Operand in the clear cycle is not accepted.
  - Next frame 1,1 | 0,0,0 gives out_bit = 1, out_diff = +2, with no carry-over from the aborted frame.
- rst_n pulsed low asynchronously mid-frame (between edges), and separately while in HOLD:
  - Outputs go to reset values immediately.
  - A subsequent full frame decides correctly.
